fcmp_pipe: RTL

Pipelined floating-point compare/select stage for the single-precision FPU. It accepts one operation per cycle over a valid/ready handshake and computes feq, flt, fle, fmin or fmax on two IEEE-754 binary32 operands. Results, tagged with the request tag, are returned after two register stages. Ordering follows the FPU-wide compare semantics: zero-exponent inputs are flushed to +0, and NaNs are not special-cased.

---
 rtl/fcmp_pipe.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fcmp_pipe.sv
// ---------------------------------------------------------------------------
// fcmp_pipe
//
// Two-stage pipelined compare/select unit for single-precision operands.
// Each accepted request computes feq, flt, fle, fmin or fmax and returns the
// result tagged with the tag that came in with the request.
//
// Ordering follows the FPU-wide compare semantics. Operands with a zero
// exponent are flushed to +0. NaNs get no special treatment: they order by
// their bit patterns like any other value.
//
// Ports
//   i_clk        clock, all state changes on the rising edge
//   i_rstn       synchronous active-low reset
//   i_in_valid   request present
//   o_in_ready   stage can take the request this cycle
//   i_in_op      000 feq, 001 flt, 010 fle, 011 fmin, 100 fmax, others -> y=0
//   i_in_x1/x2   binary32 operands
//   i_in_tag     opaque request tag
//   o_out_valid  result present
//   i_out_ready  consumer takes the result this cycle
//   o_out_y      result word
//   o_out_tag    tag belonging to o_out_y
// ---------------------------------------------------------------------------
module fcmp_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_in_op,
    input  logic [31:0]      i_in_x1,
    input  logic [31:0]      i_in_x2,
    input  logic [TAG_W-1:0] i_in_tag,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_out_y,
    output logic [TAG_W-1:0] o_out_tag
);

    localparam logic [2:0] OP_FEQ  = 3'b000;
    localparam logic [2:0] OP_FLT  = 3'b001;
    localparam logic [2:0] OP_FLE  = 3'b010;
    localparam logic [2:0] OP_FMIN = 3'b011;
    localparam logic [2:0] OP_FMAX = 3'b100;

    // Maps a binary32 value onto an unsigned key whose integer order matches
    // the numeric order. Positives get the top bit set and keep their
    // magnitude; negatives have the top bit clear and an inverted magnitude,
    // so larger magnitudes sort lower. A zero exponent collapses to the +0 key.
    function automatic logic [31:0] orderKey(input logic [31:0] x);
        logic       w_zero;
        logic       w_s;
        logic [7:0] w_e;
        logic [22:0] w_m;
        w_zero = (x[30:23] == 8'd0);
        w_s    = w_zero ? 1'b1 : ~x[31];
        w_e    = w_s ? x[30:23] : ~x[30:23];
        w_m    = w_zero ? 23'd0 : (w_s ? x[22:0] : ~x[22:0]);
        return {w_s, w_e, w_m};
    endfunction

    // Stage 1 registers
    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;
    logic [31:0]      r_s1_x1;
    logic [31:0]      r_s1_x2;
    logic [31:0]      r_s1_key1;
    logic [31:0]      r_s1_key2;

    // Stage 2 registers
    logic             r_s2_valid;
    logic [31:0]      r_s2_y;
    logic [TAG_W-1:0] r_s2_tag;

    logic             w_s2_load;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_eq;
    logic             w_lt;
    logic [31:0]      w_s1_y;

    // Stage 2 takes over stage 1 when it is empty or its own result leaves
    // this cycle; stage 1 can refill whenever it is empty or draining. This
    // is what lets a full pipe accept again in the same cycle out_ready rises.
    assign w_s2_load  = r_s1_valid & (~r_s2_valid | i_out_ready);
    assign w_in_ready = ~r_s1_valid | w_s2_load;
    assign w_accept   = i_in_valid & w_in_ready;

    assign w_eq = (r_s1_key1 == r_s1_key2);
    assign w_lt = (r_s1_key1 <  r_s1_key2);

    // Result selection from the stage 1 keys. fmax uses "not less than" so
    // that equal keys pick x1, matching fmin which also picks x1 on a tie.
    always_comb begin
        w_s1_y = 32'd0;
        case (r_s1_op)
            OP_FEQ:  w_s1_y = {31'd0, w_eq};
            OP_FLT:  w_s1_y = {31'd0, w_lt};
            OP_FLE:  w_s1_y = {31'd0, w_lt | w_eq};
            OP_FMIN: w_s1_y = (w_lt | w_eq) ? r_s1_x1 : r_s1_x2;
            OP_FMAX: w_s1_y = (~w_lt) ? r_s1_x1 : r_s1_x2;
            default: w_s1_y = 32'd0;
        endcase
    end

    // Stage 1: capture the request together with both precomputed keys.
    // Holds all contents while stage 2 is stalled.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 3'd0;
            r_s1_tag   <= '0;
            r_s1_x1    <= 32'd0;
            r_s1_x2    <= 32'd0;
            r_s1_key1  <= 32'd0;
            r_s1_key2  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_op    <= i_in_op;
                r_s1_tag   <= i_in_tag;
                r_s1_x1    <= i_in_x1;
                r_s1_x2    <= i_in_x2;
                r_s1_key1  <= orderKey(i_in_x1);
                r_s1_key2  <= orderKey(i_in_x2);
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: output register. Data only changes on a load, so a stalled
    // result and an emptied stage both keep their last word and tag.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_s2_valid <= 1'b0;
            r_s2_y     <= 32'd0;
            r_s2_tag   <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_s2_y     <= w_s1_y;
                r_s2_tag   <= r_s1_tag;
            end else if (i_out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_s2_valid;
    assign o_out_y     = r_s2_y;
    assign o_out_tag   = r_s2_tag;

endmodule
